// File: rtl/seq_det_pkg.sv
// Shared definitions for the 0110 detector family: FSM states, default widths
// and the saturating increment used by the statistics counters.
package seq_det_pkg;

    localparam int DEF_WIN_LEN = 64;
    localparam int DEF_CNT_W   = 8;
    localparam int DEF_GAP_W   = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Increment that sticks at max_value instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max_value);
        return (value >= max_value) ? max_value : value + 32'd1;
    endfunction

endpackage

// File: rtl/match_window_counter_if.sv
// Result/statistics bus between the match window counter and its consumer.
interface match_window_counter_if #(
    parameter int CNT_W = 8,
    parameter int GAP_W = 8
);
    logic [CNT_W-1:0] out_count;
    logic             out_valid;
    logic             out_ready;
    logic             dropped;
    logic [GAP_W-1:0] min_gap;
    logic             gap_valid;

    modport master (
        output out_count, out_valid, dropped, min_gap, gap_valid,
        input  out_ready
    );

    modport slave (
        input  out_count, out_valid, dropped, min_gap, gap_valid,
        output out_ready
    );
endinterface

// File: rtl/win_timer.sv
// Modulo-WIN_LEN cycle counter; last flags the final cycle of each window.
module win_timer #(
    parameter int WIN_LEN = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    input  logic advance,
    output logic last
);
    localparam int TW = $clog2(WIN_LEN);

    logic [TW-1:0] cnt_reg;

    assign last = (cnt_reg == TW'(WIN_LEN - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (restart) begin
            cnt_reg <= '0;
        end else if (advance) begin
            cnt_reg <= last ? '0 : cnt_reg + TW'(1);
        end
    end
endmodule

// File: rtl/match_window_counter.sv
// Counts detector match pulses per WIN_LEN-clock window, publishes each count
// through a valid/ready result register and tracks the minimum match spacing.
module match_window_counter
    import seq_det_pkg::*;
#(
    parameter int WIN_LEN = DEF_WIN_LEN,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int GAP_W   = DEF_GAP_W
) (
    input  logic clk,
    input  logic reset,
    input  logic z,
    input  logic enable,
    match_window_counter_if.master res
);
    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);
    localparam logic [31:0] GAP_MAX = 32'((64'd1 << GAP_W) - 64'd1);

    state_t state_reg, state_next;
    logic   active, start, restart, last;

    logic [CNT_W-1:0] match_reg, match_inc, candidate;
    logic [CNT_W-1:0] result_reg;
    logic             valid_reg, dropped_reg;
    logic [GAP_W-1:0] gap_reg, gap_inc, min_gap_reg;
    logic             seen_reg, gap_valid_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (enable)  state_next = RUN;
            RUN:     if (!enable) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A RUN cycle with enable low is the exit cycle and is not measured.
    always_comb begin
        active = (state_reg == RUN) && enable;
        start  = (state_reg == IDLE) && enable;
    end

    assign restart = ~active;

    win_timer #(.WIN_LEN(WIN_LEN)) u_win_timer (
        .clk     (clk),
        .reset   (reset),
        .restart (restart),
        .advance (active),
        .last    (last)
    );

    assign match_inc = CNT_W'(sat_inc(32'(match_reg), CNT_MAX));
    assign candidate = z ? match_inc : match_reg;
    assign gap_inc   = GAP_W'(sat_inc(32'(gap_reg), GAP_MAX));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                   match_reg <= '0;
        else if (!active || last)    match_reg <= '0;
        else if (z)                  match_reg <= match_inc;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_reg  <= '0;
            valid_reg   <= 1'b0;
            dropped_reg <= 1'b0;
        end else if (active && last) begin
            if (!valid_reg || res.out_ready) begin
                result_reg <= candidate;
                valid_reg  <= 1'b1;
            end else begin
                dropped_reg <= 1'b1;
            end
        end else if (valid_reg && res.out_ready) begin
            valid_reg <= 1'b0;
        end
    end

    // gap_reg restarts at 1 on each pulse so it equals the pulse distance when the next one lands.
    always_ff @(posedge clk or posedge reset) begin
        if (reset || start) begin
            seen_reg      <= 1'b0;
            gap_reg       <= '0;
            min_gap_reg   <= '1;
            gap_valid_reg <= 1'b0;
        end else if (active) begin
            if (z) begin
                if (seen_reg) begin
                    if (gap_reg < min_gap_reg) min_gap_reg <= gap_reg;
                    gap_valid_reg <= 1'b1;
                end
                seen_reg <= 1'b1;
                gap_reg  <= GAP_W'(1);
            end else if (seen_reg) begin
                gap_reg <= gap_inc;
            end
        end
    end

    assign res.out_count = result_reg;
    assign res.out_valid = valid_reg;
    assign res.dropped   = dropped_reg;
    assign res.min_gap   = min_gap_reg;
    assign res.gap_valid = gap_valid_reg;
endmodule

// File: tb/tb_match_window_counter.sv
// Bench for match_window_counter: two instances (8-clock window / 8-bit count and
// 16-clock window / 3-bit count) checked against a cycle-indexed reference model.
module tb_match_window_counter;
    localparam int GAP_MAX = 255;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic z_a = 1'b0, en_a = 1'b0;
    logic z_b = 1'b0, en_b = 1'b0;

    match_window_counter_if #(.CNT_W(8), .GAP_W(8)) ifa ();
    match_window_counter_if #(.CNT_W(3), .GAP_W(8)) ifb ();

    match_window_counter #(.WIN_LEN(8), .CNT_W(8), .GAP_W(8)) dut_a (
        .clk(clk), .reset(reset), .z(z_a), .enable(en_a), .res(ifa)
    );
    match_window_counter #(.WIN_LEN(16), .CNT_W(3), .GAP_W(8)) dut_b (
        .clk(clk), .reset(reset), .z(z_b), .enable(en_b), .res(ifb)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    // Reference model: window position, unbounded match tally, pulse timestamps.
    int win[2]  = '{8, 16};
    int cmax[2] = '{255, 7};
    bit m_run[2], m_valid[2], m_drop[2], m_gv[2];
    int m_pos[2], m_matches[2], m_cnt[2], m_last[2], m_min[2];

    wire [18:0] obs_a = {ifa.out_count, ifa.out_valid, ifa.dropped, ifa.min_gap, ifa.gap_valid};
    wire [13:0] obs_b = {ifb.out_count, ifb.out_valid, ifb.dropped, ifb.min_gap, ifb.gap_valid};

    function automatic logic [18:0] exp_a();
        return {m_cnt[0][7:0], m_valid[0], m_drop[0], m_min[0][7:0], m_gv[0]};
    endfunction

    function automatic logic [13:0] exp_b();
        return {m_cnt[1][2:0], m_valid[1], m_drop[1], m_min[1][7:0], m_gv[1]};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_run[k] = 0; m_valid[k] = 0; m_drop[k] = 0; m_gv[k] = 0;
            m_pos[k] = 0; m_matches[k] = 0; m_cnt[k] = 0; m_last[k] = -1; m_min[k] = GAP_MAX;
        end
    endtask

    task automatic model_step(input int k, input logic zi, input logic en, input logic rdy);
        bit fire;
        int gap;
        fire = 0;
        if (!m_run[k]) begin
            if (en) begin
                m_run[k] = 1; m_pos[k] = 0; m_matches[k] = 0;
                m_last[k] = -1; m_min[k] = GAP_MAX; m_gv[k] = 0;
            end
        end else if (!en) begin
            m_run[k] = 0;
        end else begin
            if (zi) begin
                if (m_last[k] >= 0) begin
                    gap = cyc - m_last[k];
                    if (gap > GAP_MAX) gap = GAP_MAX;
                    if (gap < m_min[k]) m_min[k] = gap;
                    m_gv[k] = 1;
                end
                m_last[k] = cyc;
            end
            m_matches[k] += int'(zi);
            if (m_pos[k] == win[k] - 1) begin
                fire = 1;
                m_pos[k] = 0;
            end else begin
                m_pos[k]++;
            end
        end
        if (fire) begin
            if (!m_valid[k] || rdy) begin
                m_cnt[k] = (m_matches[k] > cmax[k]) ? cmax[k] : m_matches[k];
                m_valid[k] = 1;
                $display("window result dut%0d count=%0d cycle=%0d", k, m_cnt[k], cyc);
            end else begin
                m_drop[k] = 1;
            end
            m_matches[k] = 0;
        end else if (m_valid[k] && rdy) begin
            m_valid[k] = 0;
        end
    endtask

    // Drives one clock's inputs (called at posedge+1), advances the model, returns at next posedge+1.
    task automatic step(input logic za, input logic ena, input logic ra,
                        input logic zb, input logic enb, input logic rb);
        z_a = za; en_a = ena; ifa.out_ready = ra;
        z_b = zb; en_b = enb; ifb.out_ready = rb;
        model_step(0, za, ena, ra);
        model_step(1, zb, enb, rb);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        z_a = 0; en_a = 0; ifa.out_ready = 0;
        z_b = 0; en_b = 0; ifb.out_ready = 0;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Runs one window on dut_a with z from pattern bits; ready held at rdy except
    // rdy_last applies on the window-end cycle.
    task automatic window_a(input logic [7:0] pattern, input logic rdy, input logic rdy_last);
        for (int i = 0; i < 8; i++)
            step(pattern[i], 1'b1, (i == 7) ? rdy_last : rdy, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        model_reset();
        #2;
        n_cmp++;
        if (obs_a !== 19'h001FE) begin
            n_fail++; $display("FAIL reset_a: got %h expected %h", obs_a, 19'h001FE);
        end
        n_cmp++;
        if (obs_b !== 14'h01FE) begin
            n_fail++; $display("FAIL reset_b: got %h expected %h", obs_b, 14'h01FE);
        end
        do_reset();
        n_cmp++;
        if (obs_a !== exp_a()) begin
            n_fail++; $display("FAIL reset_release: got %h expected %h", obs_a, exp_a());
        end
    endtask

    task automatic test_window_basic();
        do_reset();
        step(0, 1, 1, 0, 0, 0);
        window_a(8'b1001_0010, 1'b1, 1'b1);
        n_cmp++;
        if ({ifa.out_count, ifa.out_valid, ifa.dropped} !== {8'd3, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL basic_result: got %0d/%b/%b expected 3/1/0",
                               ifa.out_count, ifa.out_valid, ifa.dropped);
        end
        n_cmp++;
        if (obs_a !== exp_a()) begin
            n_fail++; $display("FAIL basic_model: got %h expected %h", obs_a, exp_a());
        end
        step(0, 1, 1, 0, 0, 0);
        n_cmp++;
        if (ifa.out_valid !== 1'b0 || obs_a !== exp_a()) begin
            n_fail++; $display("FAIL basic_consume: got %h expected %h", obs_a, exp_a());
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        step(0, 1, 0, 0, 0, 0);
        window_a(8'b0101_0001, 1'b0, 1'b0);
        window_a(8'b1000_0100, 1'b0, 1'b0);
        n_cmp++;
        if ({ifa.out_count, ifa.out_valid, ifa.dropped} !== {8'd3, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL bp_hold: got %0d/%b/%b expected 3/1/1",
                               ifa.out_count, ifa.out_valid, ifa.dropped);
        end
        step(0, 1, 1, 0, 0, 0);
        n_cmp++;
        if ({ifa.out_valid, ifa.dropped} !== 2'b01 || obs_a !== exp_a()) begin
            n_fail++; $display("FAIL bp_release: got %h expected %h", obs_a, exp_a());
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        step(0, 1, 0, 0, 0, 0);
        window_a(8'b0011_0100, 1'b0, 1'b0);
        window_a(8'b0010_0010, 1'b0, 1'b1);
        n_cmp++;
        if ({ifa.out_count, ifa.out_valid, ifa.dropped} !== {8'd2, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL b2b_reload: got %0d/%b/%b expected 2/1/0",
                               ifa.out_count, ifa.out_valid, ifa.dropped);
        end
        n_cmp++;
        if (obs_a !== exp_a()) begin
            n_fail++; $display("FAIL b2b_model: got %h expected %h", obs_a, exp_a());
        end
    endtask

    task automatic test_saturation();
        do_reset();
        step(0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 16; i++) step(0, 0, 0, 1, 1, 1);
        n_cmp++;
        if (obs_b !== {3'd7, 1'b1, 1'b0, 8'd1, 1'b1}) begin
            n_fail++; $display("FAIL saturate: got %h expected %h", obs_b, {3'd7, 1'b1, 1'b0, 8'd1, 1'b1});
        end
        n_cmp++;
        if (obs_b !== exp_b()) begin
            n_fail++; $display("FAIL saturate_model: got %h expected %h", obs_b, exp_b());
        end
    endtask

    task automatic test_overlap_gap();
        do_reset();
        step(0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 6; i++) step((i == 2) || (i == 5), 1, 1, 0, 0, 0);
        n_cmp++;
        if ({ifa.min_gap, ifa.gap_valid} !== {8'd3, 1'b1}) begin
            n_fail++; $display("FAIL overlap_gap: got %0d/%b expected 3/1", ifa.min_gap, ifa.gap_valid);
        end
    endtask

    task automatic test_enable_drop();
        do_reset();
        step(0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step((i == 1) || (i == 3), 1, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        n_cmp++;
        if ({ifa.out_valid, ifa.min_gap, ifa.gap_valid} !== {1'b0, 8'hFF, 1'b0}) begin
            n_fail++; $display("FAIL endrop_restart: got %b/%0d/%b expected 0/255/0",
                               ifa.out_valid, ifa.min_gap, ifa.gap_valid);
        end
        for (int i = 0; i < 8; i++) begin
            step((i == 2) || (i == 6), 1, 1, 0, 0, 0);
            n_cmp++;
            if (obs_a !== exp_a()) begin
                n_fail++; $display("FAIL endrop_win[%0d]: got %h expected %h", i, obs_a, exp_a());
            end
        end
        n_cmp++;
        if ({ifa.out_count, ifa.out_valid, ifa.min_gap, ifa.gap_valid} !== {8'd2, 1'b1, 8'd4, 1'b1}) begin
            n_fail++; $display("FAIL endrop_result: got %0d/%b/%0d/%b expected 2/1/4/1",
                               ifa.out_count, ifa.out_valid, ifa.min_gap, ifa.gap_valid);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(0, 1, 0, 0, 1, 0);
        for (int i = 0; i < 8; i++) step(i[0], 1, 0, 1, 1, 0);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        n_cmp++;
        if (obs_a !== 19'h001FE || obs_b !== 14'h01FE) begin
            n_fail++; $display("FAIL reset_mid: got %h/%h expected 001fe/01fe", obs_a, obs_b);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_random();
        logic za, ea, ra, zb, eb, rb;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            za = ($urandom_range(0, 99) < 35);
            zb = ($urandom_range(0, 99) < 60);
            ea = ($urandom_range(0, 29) != 0);
            eb = ($urandom_range(0, 49) != 0);
            ra = ($urandom_range(0, 1) == 1);
            rb = ($urandom_range(0, 3) == 0);
            step(za, ea, ra, zb, eb, rb);
            n_cmp++;
            if (obs_a !== exp_a()) begin
                n_fail++; $display("FAIL random_a[%0d]: got %h expected %h", i, obs_a, exp_a());
            end
            n_cmp++;
            if (obs_b !== exp_b()) begin
                n_fail++; $display("FAIL random_b[%0d]: got %h expected %h", i, obs_b, exp_b());
            end
        end
    endtask

    initial begin
        ifa.out_ready = 1'b0;
        ifb.out_ready = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_window_basic();
        test_backpressure();
        test_back_to_back();
        test_saturation();
        test_overlap_gap();
        test_enable_drop();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
